// File: rtl/drawbridge_pkg.sv
// drawbridge_pkg: state encoding, side constants and default timing for the drawbridge scheduler
package drawbridge_pkg;
  typedef enum logic [2:0] {
    INIT      = 3'd0,
    ROAD_OPEN = 3'd1,
    ROAD_STOP = 3'd2,
    RAISING   = 3'd3,
    BOAT_PASS = 3'd4,
    LOWERING  = 3'd5,
    FAULT     = 3'd6
  } state_t;
  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;
  localparam int MIN_ROAD_DEF = 100;
  localparam int CLEAR_DEF    = 20;
  localparam int BOAT_WIN_DEF = 200;
  localparam int MOVE_TMO_DEF = 500;
  localparam int TW_DEF       = 10;
endpackage

// File: rtl/bridge_passage_scheduler_if.sv
// bridge_passage_scheduler_if: boat requests, deck sensors and bridge/traffic commands
interface bridge_passage_scheduler_if;
  logic       BoatReqA;
  logic       BoatReqB;
  logic       BoatPassed;
  logic       CarsOnBridge;
  logic       BridgeHigh;
  logic       BridgeLow;
  logic       RoadStop;
  logic       LiftCmd;
  logic       LowerCmd;
  logic       BoatGoA;
  logic       BoatGoB;
  logic       Alarm;
  logic [2:0] StateDbg;
  modport master (
    output BoatReqA, BoatReqB, BoatPassed, CarsOnBridge, BridgeHigh, BridgeLow,
    input  RoadStop, LiftCmd, LowerCmd, BoatGoA, BoatGoB, Alarm, StateDbg
  );
  modport slave (
    input  BoatReqA, BoatReqB, BoatPassed, CarsOnBridge, BridgeHigh, BridgeLow,
    output RoadStop, LiftCmd, LowerCmd, BoatGoA, BoatGoB, Alarm, StateDbg
  );
endinterface

// File: rtl/bridge_timer.sv
// bridge_timer: saturating up-counter cleared synchronously on every state change
module bridge_timer #(
  parameter int TW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic [TW-1:0] cnt
);
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/bridge_passage_scheduler.sv
// bridge_passage_scheduler: sequences road closure, deck lift, round-robin boat grants and lowering
module bridge_passage_scheduler
  import drawbridge_pkg::*;
#(
  parameter int MIN_ROAD = MIN_ROAD_DEF,
  parameter int CLEAR    = CLEAR_DEF,
  parameter int BOAT_WIN = BOAT_WIN_DEF,
  parameter int MOVE_TMO = MOVE_TMO_DEF,
  parameter int TW       = TW_DEF
) (
  input logic                        Clk,
  input logic                        Reset,
  bridge_passage_scheduler_if.slave  bus
);
  localparam logic [TW-1:0] MR = TW'(MIN_ROAD - 1);
  localparam logic [TW-1:0] CL = TW'(CLEAR - 1);
  localparam logic [TW-1:0] BW = TW'(BOAT_WIN - 1);
  localparam logic [TW-1:0] MT = TW'(MOVE_TMO - 1);
  state_t        state_q, state_d;
  logic [1:0]    pend_q, pend_d;
  logic          grant_q, grant_d, last_q, last_d, dead_q, dead_d;
  logic          road_stop_q, road_stop_d, lift_q, lift_d, lower_q, lower_d;
  logic          go_a_q, go_a_d, go_b_q, go_b_d, alarm_q, alarm_d;
  logic          regrant, fault, pick, other_pend, clr;
  logic [TW-1:0] timer;
  bridge_timer #(.TW(TW)) u_timer (.clk(Clk), .rst(Reset), .clr(clr), .cnt(timer));
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    regrant    = 1'b0;
    other_pend = grant_q ? pend_q[0] : pend_q[1];
    pick       = (pend_q[1] && (!pend_q[0] || last_q == SIDE_A)) ? SIDE_B : SIDE_A;
    fault      = state_q != INIT && ((bus.BridgeHigh && bus.BridgeLow) ||
                 (bus.CarsOnBridge && state_q inside {RAISING, BOAT_PASS, LOWERING}) ||
                 (state_q == ROAD_OPEN && !bus.BridgeLow));
    case (state_q)
      INIT:      state_d = (bus.BridgeLow && !bus.BridgeHigh) ? ROAD_OPEN : LOWERING;
      ROAD_OPEN: if (|pend_q && timer >= MR) state_d = ROAD_STOP;
      ROAD_STOP: if (timer >= CL && !bus.CarsOnBridge) state_d = RAISING;
      RAISING:
        if (bus.BridgeHigh) begin
          state_d = BOAT_PASS;
          grant_d = pick;
          last_d  = pick;
        end else if (timer == MT) state_d = FAULT;
      BOAT_PASS:
        // a dead cycle separating two grants ignores BoatPassed
        if (!dead_q && (bus.BoatPassed || timer == BW)) begin
          if (other_pend) begin
            regrant = 1'b1;
            grant_d = !grant_q;
            last_d  = !grant_q;
          end else state_d = LOWERING;
        end
      LOWERING:
        if (bus.BridgeLow) state_d = ROAD_OPEN;
        else if (timer == MT) state_d = FAULT;
      default:   state_d = FAULT;
    endcase
    if (fault) begin
      state_d = FAULT;
      regrant = 1'b0;
    end
    clr         = regrant || state_d != state_q;
    dead_d      = regrant;
    road_stop_d = state_d != ROAD_OPEN;
    lift_d      = state_d == RAISING;
    lower_d     = state_d == LOWERING;
    go_a_d      = state_d == BOAT_PASS && !regrant && grant_d == SIDE_A;
    go_b_d      = state_d == BOAT_PASS && !regrant && grant_d == SIDE_B;
    alarm_d     = state_d == FAULT;
    pend_d[0]   = bus.BoatReqA || (pend_q[0] && !(bus.BoatPassed && go_a_q));
    pend_d[1]   = bus.BoatReqB || (pend_q[1] && !(bus.BoatPassed && go_b_q));
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q     <= INIT;
      pend_q      <= 2'b00;
      grant_q     <= SIDE_B;
      last_q      <= SIDE_B;
      dead_q      <= 1'b0;
      road_stop_q <= 1'b1;
      lift_q      <= 1'b0;
      lower_q     <= 1'b0;
      go_a_q      <= 1'b0;
      go_b_q      <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      dead_q      <= dead_d;
      road_stop_q <= road_stop_d;
      lift_q      <= lift_d;
      lower_q     <= lower_d;
      go_a_q      <= go_a_d;
      go_b_q      <= go_b_d;
      alarm_q     <= alarm_d;
    end
  assign bus.RoadStop = road_stop_q;
  assign bus.LiftCmd  = lift_q;
  assign bus.LowerCmd = lower_q;
  assign bus.BoatGoA  = go_a_q;
  assign bus.BoatGoB  = go_b_q;
  assign bus.Alarm    = alarm_q;
  assign bus.StateDbg = state_q;
endmodule

// File: tb/tb_bridge_passage_scheduler.sv
// tb_bridge_passage_scheduler: per-cycle vector table plus directed sequences for timeouts, faults and reset
module tb_bridge_passage_scheduler;
  typedef struct packed {
    logic [6:0] in;
    logic [2:0] st;
    logic [5:0] out;
  } vec_t;
  logic clk, rst;
  int   n_chk, n_fail;
  vec_t vt[$];
  bridge_passage_scheduler_if bus ();
  bridge_passage_scheduler #(.MIN_ROAD(4), .CLEAR(3), .BOAT_WIN(8), .MOVE_TMO(10), .TW(10)) dut (
    .Clk(clk), .Reset(rst), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t v(input logic [6:0] i, input logic [2:0] s, input logic [5:0] o);
    return '{i, s, o};
  endfunction
  function automatic logic [5:0] outs();
    return {bus.RoadStop, bus.LiftCmd, bus.LowerCmd, bus.BoatGoA, bus.BoatGoB, bus.Alarm};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic apply(input logic [6:0] i);
    {rst, bus.BoatReqA, bus.BoatReqB, bus.BoatPassed, bus.CarsOnBridge, bus.BridgeHigh, bus.BridgeLow} = i;
  endtask
  task automatic check(input string n, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic chk_so(input string n, input logic [2:0] s, input logic [5:0] o);
    check(n, {bus.StateDbg, outs()}, {s, o});
  endtask
  task automatic wait_st(input string n, input logic [2:0] s, input int max);
    int k = 0;
    do begin
      tick();
      k++;
    end while (bus.StateDbg != s && k < max);
    check(n, {6'd0, bus.StateDbg}, {6'd0, s});
  endtask
  task automatic pulse_a();
    bus.BoatReqA = 1'b1;
    tick();
    bus.BoatReqA = 1'b0;
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    apply(7'b1000001);
    // inputs {rst,reqA,reqB,passed,cars,H,L}; outputs {RoadStop,Lift,Lower,GoA,GoB,Alarm}
    vt.push_back(v(7'b1000001, 3'd0, 6'b100000));
    vt.push_back(v(7'b0000001, 3'd1, 6'b000000));
    vt.push_back(v(7'b0100001, 3'd1, 6'b000000));
    vt.push_back(v(7'b0000001, 3'd1, 6'b000000));
    vt.push_back(v(7'b0000001, 3'd1, 6'b000000));
    vt.push_back(v(7'b0000001, 3'd2, 6'b100000));
    vt.push_back(v(7'b0000001, 3'd2, 6'b100000));
    vt.push_back(v(7'b0000001, 3'd2, 6'b100000));
    vt.push_back(v(7'b0000001, 3'd3, 6'b110000));
    vt.push_back(v(7'b0000000, 3'd3, 6'b110000));
    vt.push_back(v(7'b0000010, 3'd4, 6'b100100));
    vt.push_back(v(7'b0001010, 3'd5, 6'b101000));
    vt.push_back(v(7'b0000001, 3'd1, 6'b000000));
    for (int i = 0; i < 6; i++) vt.push_back(v(7'b0000001, 3'd1, 6'b000000));
    vt.push_back(v(7'b1000001, 3'd0, 6'b100000));
    for (int i = 0; i < 4; i++) vt.push_back(v(7'b0000001, 3'd1, 6'b000000));
    vt.push_back(v(7'b0110001, 3'd1, 6'b000000));
    vt.push_back(v(7'b0000001, 3'd2, 6'b100000));
    vt.push_back(v(7'b0000001, 3'd2, 6'b100000));
    vt.push_back(v(7'b0000001, 3'd2, 6'b100000));
    vt.push_back(v(7'b0000001, 3'd3, 6'b110000));
    vt.push_back(v(7'b0000000, 3'd3, 6'b110000));
    vt.push_back(v(7'b0000010, 3'd4, 6'b100100));
    vt.push_back(v(7'b0001010, 3'd4, 6'b100000));
    vt.push_back(v(7'b0000010, 3'd4, 6'b100010));
    vt.push_back(v(7'b0001010, 3'd5, 6'b101000));
    vt.push_back(v(7'b0000001, 3'd1, 6'b000000));
    foreach (vt[i]) begin
      apply(vt[i].in);
      tick();
      chk_so($sformatf("vec%0d", i), vt[i].st, vt[i].out);
    end
    pulse_a();
    wait_st("t3_stop", 3'd2, 10);
    bus.CarsOnBridge = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_so($sformatf("t3_hold%0d", i), 3'd2, 6'b100000);
    end
    bus.CarsOnBridge = 1'b0;
    tick();
    chk_so("t3_raise", 3'd3, 6'b110000);
    bus.BridgeLow = 1'b0;
    bus.BridgeHigh = 1'b1;
    tick();
    chk_so("t6_grant_a", 3'd4, 6'b100100);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_so($sformatf("t6_win%0d", i), 3'd4, 6'b100100);
    end
    tick();
    chk_so("t6_expire", 3'd5, 6'b101000);
    bus.BridgeHigh = 1'b0;
    bus.BridgeLow = 1'b1;
    tick();
    chk_so("t6_road", 3'd1, 6'b000000);
    repeat (3) tick();
    chk_so("t6_pend_wait", 3'd1, 6'b000000);
    tick();
    chk_so("t6_pend_kept", 3'd2, 6'b100000);
    wait_st("t6_raise", 3'd3, 6);
    bus.BridgeLow = 1'b0;
    bus.BridgeHigh = 1'b1;
    tick();
    chk_so("t6_reserve", 3'd4, 6'b100100);
    bus.BoatPassed = 1'b1;
    tick();
    bus.BoatPassed = 1'b0;
    chk_so("t6_lower", 3'd5, 6'b101000);
    bus.BridgeHigh = 1'b0;
    bus.BridgeLow = 1'b1;
    tick();
    chk_so("t6_road2", 3'd1, 6'b000000);
    bus.BridgeHigh = 1'b1;
    tick();
    chk_so("t4_hl", 3'd6, 6'b100001);
    bus.BridgeHigh = 1'b0;
    bus.BoatReqB = 1'b1;
    repeat (3) tick();
    bus.BoatReqB = 1'b0;
    chk_so("t4_sticky", 3'd6, 6'b100001);
    rst = 1'b1;
    tick();
    chk_so("t4_reset", 3'd0, 6'b100000);
    rst = 1'b0;
    tick();
    chk_so("t4_init_exit", 3'd1, 6'b000000);
    pulse_a();
    wait_st("t4_raise", 3'd3, 12);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_so($sformatf("t4_raising%0d", i), 3'd3, 6'b110000);
    end
    tick();
    chk_so("t4_tmo", 3'd6, 6'b100001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pulse_a();
    wait_st("t5_raise", 3'd3, 12);
    bus.BridgeLow = 1'b0;
    bus.BridgeHigh = 1'b1;
    tick();
    chk_so("t5_pass", 3'd4, 6'b100100);
    #3;
    rst = 1'b1;
    #1;
    chk_so("t5_async", 3'd0, 6'b100000);
    #2;
    rst = 1'b0;
    tick();
    chk_so("t5_recover", 3'd5, 6'b101000);
    tick();
    chk_so("t5_lowering", 3'd5, 6'b101000);
    bus.BridgeHigh = 1'b0;
    bus.BridgeLow = 1'b1;
    tick();
    chk_so("t5_road", 3'd1, 6'b000000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
